// File: rtl/rv32_fetch_ctrl.sv
// rv32_fetch_ctrl: instruction-fetch sequencer for the rv32imc single-stage core.
//
// Issues word-aligned fetches over a req/ack handshake, reassembles 32-bit
// instructions that straddle a word boundary, hands one instruction at a time
// to decode and steers the PC register (stall / size / overwrite).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fetch_enable          permits starting new fetches
//   pc_current            current PC from the PC register
//   pc_stall              PC register stall
//   pc_is_compressed      PC register size select (advance by 2 when set, else 4)
//   pc_overwrite_enable   PC overwrite enable (mirrors redirect_valid)
//   pc_overwrite_data     PC overwrite value (mirrors redirect_pc)
//   mem_req, mem_addr     registered fetch request and word-aligned address
//   mem_ack, mem_rdata    response strobe and data (same cycle)
//   mem_err               access fault, qualified by mem_ack
//   redirect_valid/_pc    control-flow change and its target
//   instr_valid/_ready    handshake towards decode
//   instr, instr_pc       instruction (upper half zero when compressed) and its PC
//   instr_fault           fetch fault flag for instr
//
// Parameter MEM_TIMEOUT: cycles to wait for mem_ack before re-issuing (0 = off).
// Build option: define RV32_FETCH_FAULT_EN to turn an erroring ack into a
// faulting instruction; otherwise mem_err is ignored and instr_fault is 0.
module rv32_fetch_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic [31:0] pc_current,
    output logic        pc_stall,
    output logic        pc_is_compressed,
    output logic        pc_overwrite_enable,
    output logic [31:0] pc_overwrite_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);

    typedef enum logic [2:0] {StIdle, StFetch0, StFetch1, StValid, StDrain} state_e;

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] TmoLast = (MEM_TIMEOUT == 0) ? '0 : CntW'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       instr_pc_q, instr_pc_d;
    logic [15:0]       low_half_q, low_half_d;
    logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              tmo_hit;
    logic              err_hit;
    logic              fire;
    logic [31:0]       next_pc;

`ifdef RV32_FETCH_FAULT_EN
    logic              fault_q, fault_d;
    assign err_hit     = mem_err;
    assign instr_fault = fault_q;
`else
    logic              unused_mem_err;
    assign unused_mem_err = mem_err;
    assign err_hit        = 1'b0;
    assign instr_fault    = 1'b0;
`endif

    // Request has been high for MEM_TIMEOUT cycles without an ack.
    assign tmo_hit = (MEM_TIMEOUT != 0) && mem_req_q && !mem_ack && (tmo_cnt_q == TmoLast);
    assign next_pc = pc_current + (pc_is_compressed ? 32'd2 : 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            low_half_q <= '0;
            tmo_cnt_q  <= '0;
`ifdef RV32_FETCH_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            low_half_q <= low_half_d;
            tmo_cnt_q  <= tmo_cnt_d;
`ifdef RV32_FETCH_FAULT_EN
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        low_half_d = low_half_q;
`ifdef RV32_FETCH_FAULT_EN
        fault_d    = fault_q;
`endif
        if (MEM_TIMEOUT == 0 || !mem_req_q || mem_ack || tmo_hit) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                // A redirect this cycle changes pc_current, so fetch next cycle.
                if (fetch_enable && !redirect_valid) begin
                    state_d    = StFetch0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_current[31:2], 2'b00};
                end
            end
            StFetch0, StFetch1: begin
                if (redirect_valid) begin
                    // Only drain when a response is still owed to us.
                    if (mem_req_q && !mem_ack && !tmo_hit) begin
                        state_d = StDrain;
                    end else begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end
                end else if (!mem_req_q) begin
                    // Gap cycle after an ack or a timeout: (re-)issue.
                    mem_req_d = 1'b1;
                end else if (tmo_hit) begin
                    mem_req_d = 1'b0;
                end else if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    instr_pc_d = pc_current;
                    state_d    = StValid;
`ifdef RV32_FETCH_FAULT_EN
                    fault_d    = mem_err;
`endif
                    if (err_hit) begin
                        instr_d = '0;
                    end else if (state_q == StFetch1) begin
                        instr_d = {mem_rdata[15:0], low_half_q};
                    end else if (!pc_current[1]) begin
                        instr_d = (mem_rdata[1:0] != 2'b11) ? {16'h0, mem_rdata[15:0]} : mem_rdata;
                    end else if (mem_rdata[17:16] != 2'b11) begin
                        instr_d = {16'h0, mem_rdata[31:16]};
                    end else begin
                        // Upper half opens a 32-bit instruction; fetch the next word.
                        low_half_d = mem_rdata[31:16];
                        mem_addr_d = mem_addr_q + 32'd4;
                        state_d    = StFetch1;
                    end
                end
            end
            StValid: begin
                if (redirect_valid) begin
                    state_d = StIdle;
                end else if (fire) begin
                    if (fetch_enable) begin
                        state_d    = StFetch0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {next_pc[31:2], 2'b00};
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                // The response is thrown away; redirects here only move the PC.
                if (mem_ack || tmo_hit) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        instr_valid         = (state_q == StValid);
        fire                = instr_valid & instr_ready & ~redirect_valid;
        pc_stall            = ~(fire | redirect_valid);
        pc_overwrite_enable = redirect_valid;
        pc_overwrite_data   = redirect_pc;
        // A faulting fetch advances the PC by a full word.
        pc_is_compressed    = ~instr_fault & (instr_q[1:0] != 2'b11);
        mem_req             = mem_req_q;
        mem_addr            = mem_addr_q;
        instr               = instr_q;
        instr_pc            = instr_pc_q;
    end

endmodule

// File: doc/rv32_fetch_ctrl.md
Name: rv32_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the rv32imc single-stage core.
- Drives the PC register's stall, compressed-size and overwrite inputs.
- Issues word-aligned fetches to instruction memory over a req/ack handshake and reassembles 32-bit instructions that straddle a word boundary.
- Hands one instruction at a time to decode and handles redirects (branch/jump/trap), including discarding in-flight responses.

Parameters:
- MEM_TIMEOUT, 0: cycles to wait for mem_ack before retrying. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_enable  in  1  permits starting new fetches
- pc_current  in  32  current PC from the PC register
- pc_stall  out  1  stall input of the PC register
- pc_is_compressed  out  1  is_compressed input of the PC register
- pc_overwrite_enable  out  1  PC overwrite enable
- pc_overwrite_data  out  32  PC overwrite value
- mem_req  out  1  fetch request
- mem_addr  out  32  word-aligned fetch address
- mem_ack  in  1  response strobe; mem_rdata valid in the same cycle
- mem_rdata  in  32  fetched word
- mem_err  in  1  access fault, qualified by mem_ack
- redirect_valid  in  1  control-flow change
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts
- instr  out  32  instruction; upper 16 bits are zero when compressed
- instr_pc  out  32  PC of instr
- instr_fault  out  1  fetch fault flag for instr

Behaviour:
- Reset: one clk and reset; reset is synchronous and active-high. On reset:
  - state=IDLE
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0
  - drop flag=0, timeout counter=0
  - Reset mid-transaction abandons the fetch; any later mem_ack arriving in IDLE is ignored.
- Combinational outputs:
  - fire = instr_valid & instr_ready & !redirect_valid
  - pc_stall = !(fire | redirect_valid)
  - pc_overwrite_enable = redirect_valid
  - pc_overwrite_data = redirect_pc
  - pc_is_compressed = (instr[1:0] != 2'b11)
- Redirect has priority over fire in the same cycle; that instruction is discarded.
- Memory handshake: mem_req and mem_addr are registered. mem_req stays high with a stable mem_addr until the cycle mem_ack=1, then drops for at least that edge.
- IDLE: if fetch_enable, go to FETCH0 with mem_addr={pc_current[31:2],2'b00} and mem_req=1.
- FETCH0, on ack:
  - pc_current[1]=0:
    - rdata[1:0]!=2'b11: instr={16'h0,rdata[15:0]}.
    - Otherwise instr=rdata.
    - Go to VALID.
  - pc_current[1]=1:
    - rdata[17:16]!=2'b11: instr={16'h0,rdata[31:16]}, go to VALID.
    - Otherwise latch rdata[31:16] as the low half and go to FETCH1 with mem_addr+4.
  - instr_pc=pc_current.
- FETCH1, on ack: instr={rdata[15:0], low_half}; go to VALID.
- VALID:
  - instr_valid=1.
  - On fire, go to IDLE, or straight to FETCH0 if fetch_enable. The fetch address is the next PC: pc_current+2 or +4 per size.
- Redirect in FETCH0/FETCH1 (a request is outstanding):
  - Go to DRAIN and keep mem_req until ack.
  - The response is discarded, then go to IDLE.
- Redirect in VALID or IDLE: instr_valid clears next cycle; go to IDLE.
- A redirect during DRAIN only updates the PC; the next fetch uses pc_current.
- Back-to-back throughput: one instruction per ack, given single-cycle memory plus one-cycle handoff.
- Timeout: with MEM_TIMEOUT=N>0, a counter runs while mem_req=1 and no ack. At count N, deassert mem_req for one cycle, clear the counter and re-issue the same address. A timeout in DRAIN goes directly to IDLE.
- Fetch wrap-around: the address arithmetic is modulo 2^32, so 32'hFFFFFFFC+4 = 0.

Optional Feature:
- Macro RV32_FETCH_FAULT_EN.
- Defined:
  - mem_err on ack forces VALID with instr_fault=1 and instr=0, skipping FETCH1.
  - Decode consumes it like an instruction; the PC advances by 4.
- Undefined:
  - mem_err is ignored and instr_fault is tied to 0.

Test Plan:
- Reset, fetch_enable=1, pc_current=32'h10000000, ack next cycle with 32'h00A00093, instr_ready=1 -> mem_addr=32'h10000000; instr=32'h00A00093, instr_pc=32'h10000000; one-cycle pc_stall=0; pc_is_compressed=0.
- pc_current=32'h10000002, rdata=32'h4505_0001 -> instr=32'h00004505, pc_is_compressed=1, a single fetch.
- pc_current=32'h10000006, first rdata=32'h0013_xxxx, second=32'hxxxx_0050 -> second request to 32'h10000008; instr=32'h00500013.
- redirect_valid=1 with redirect_pc=32'h10000100 while awaiting ack -> pc_overwrite_enable pulse; stale ack discarded, no instr_valid; next mem_addr=32'h10000100.
- MEM_TIMEOUT=4, no ack -> mem_req drops after 4 cycles for 1 cycle, then re-asserts at the same address; a late ack completes normally.
- With RV32_FETCH_FAULT_EN defined, ack with mem_err=1 -> instr_valid=1, instr_fault=1, instr=0. With it undefined -> instr_fault=0.
